autopilot_flap_ctrl: RTL and testbench

- Registered, parametrised autopilot for the bird in the obstacle game.
- Latches the incoming obstacle column and finds the lowest gap row in it.
- On each game tick, decides whether the bird must flap, then drives a timed push pulse followed by a tick-counted cooldown.
- Sits between the obstacle generator / bird position logic and the bird motion block. Its push output replaces the manual button when autopilot is enabled.

---
 rtl/autopilot_pkg.sv | 17 +
 rtl/gap_finder.sv | 19 +
 rtl/autopilot_flap_ctrl.sv | 106 ++++++++++
 tb/tb_autopilot_flap_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/autopilot_pkg.sv
// Shared state encoding and default tuning constants for the flap autopilot.
package autopilot_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    PUSH     = 2'd2,
    COOLDOWN = 2'd3
  } ap_state_t;

  localparam int DEF_ROWS           = 8;
  localparam int DEF_SCAN_MAX       = 5;
  localparam int DEF_MARGIN         = 1;
  localparam int DEF_PUSH_CYCLES    = 4;
  localparam int DEF_COOLDOWN_TICKS = 2;

endpackage

// File: rtl/gap_finder.sv
// Combinational priority search: lowest open row in 1..SCAN_MAX, SCAN_MAX if the column is closed.
module gap_finder #(
  parameter int ROWS     = 8,
  parameter int SCAN_MAX = 5,
  localparam int RW      = $clog2(ROWS)
) (
  input  logic [ROWS-1:0] obstacle,
  output logic [RW-1:0]   g
);

  // Walk downward so the lowest open row is the last one written.
  always_comb begin
    g = RW'(SCAN_MAX);
    for (int i = SCAN_MAX; i >= 1; i--) begin
      if (!obstacle[i]) g = RW'(i);
    end
  end

endmodule

// File: rtl/autopilot_flap_ctrl.sv
// Autopilot for the bird: tracks the obstacle gap, fires a timed push pulse, then a tick-counted cooldown.
module autopilot_flap_ctrl
  import autopilot_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int SCAN_MAX       = DEF_SCAN_MAX,
  parameter int MARGIN         = DEF_MARGIN,
  parameter int PUSH_CYCLES    = DEF_PUSH_CYCLES,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  localparam int RW            = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            game_tick,
  input  logic            obs_valid,
  input  logic [ROWS-1:0] obstacle,
  input  logic [RW-1:0]   bird_tail,
  input  logic [RW-1:0]   bird_head,
  output logic            push,
  output logic            busy,
  output logic [RW-1:0]   gap_row
);

  localparam int PCW = (PUSH_CYCLES > 1) ? $clog2(PUSH_CYCLES) : 1;
  localparam int CCW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [RW:0] MARG    = (RW+1)'(MARGIN);
  localparam logic [RW:0] ROW_TOP = (RW+1)'(ROWS - 1);

  ap_state_t        state, state_n;
  logic [PCW-1:0]   pcnt, pcnt_n;
  logic [CCW-1:0]   ccnt, ccnt_n;
  logic [RW-1:0]    g, eff_gap, thr, bird_min;
  logic [RW:0]      thr_sum;
  logic             flap;

  gap_finder #(.ROWS(ROWS), .SCAN_MAX(SCAN_MAX)) u_gap (
    .obstacle (obstacle),
    .g        (g)
  );

  // A column arriving on the tick itself must steer that tick's decision.
  assign eff_gap  = obs_valid ? g : gap_row;
  assign thr_sum  = {1'b0, eff_gap} + MARG;
  assign thr      = (thr_sum > ROW_TOP) ? ROW_TOP[RW-1:0] : thr_sum[RW-1:0];
  assign bird_min = (bird_tail < bird_head) ? bird_tail : bird_head;
  assign flap     = (bird_min <= thr);

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    ccnt_n  = ccnt;
    case (state)
      IDLE:  if (enable) state_n = TRACK;
      TRACK: begin
        if (game_tick && flap) begin
          state_n = PUSH;
          pcnt_n  = PCW'(PUSH_CYCLES - 1);
        end
      end
      PUSH: begin
        if (pcnt == '0) begin
          if (COOLDOWN_TICKS == 0) begin
            state_n = TRACK;
          end else begin
            state_n = COOLDOWN;
            ccnt_n  = CCW'(COOLDOWN_TICKS);
          end
        end else begin
          pcnt_n = pcnt - 1'b1;
        end
      end
      COOLDOWN: begin
        if (game_tick) begin
          if (ccnt == CCW'(1)) state_n = TRACK;
          ccnt_n = ccnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      pcnt_n  = '0;
      ccnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pcnt    <= '0;
      ccnt    <= '0;
      push    <= 1'b0;
      busy    <= 1'b0;
      gap_row <= RW'(SCAN_MAX);
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      ccnt    <= ccnt_n;
      push    <= (state_n == PUSH);
      busy    <= (state_n == PUSH) || (state_n == COOLDOWN);
      if (obs_valid) gap_row <= g;
    end
  end

endmodule

// File: tb/tb_autopilot_flap_ctrl.sv
// Bench for autopilot_flap_ctrl: three parameterisations share one stimulus stream and a cycle-level model.
module tb_autopilot_flap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       game_tick = 1'b0;
  logic       obs_valid = 1'b0;
  logic [7:0] obstacle = 8'h00;
  logic [2:0] bird_tail = 3'd0;
  logic [2:0] bird_head = 3'd0;

  logic       push_d [3];
  logic       busy_d [3];
  logic [2:0] gap_d  [3];

  // 0: defaults, 1: no cooldown, 2: MARGIN = 4
  autopilot_flap_ctrl u_dflt (
    .clk(clk), .rst_n(rst_n), .enable(enable), .game_tick(game_tick), .obs_valid(obs_valid),
    .obstacle(obstacle), .bird_tail(bird_tail), .bird_head(bird_head),
    .push(push_d[0]), .busy(busy_d[0]), .gap_row(gap_d[0]));
  autopilot_flap_ctrl #(.COOLDOWN_TICKS(0)) u_cd0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .game_tick(game_tick), .obs_valid(obs_valid),
    .obstacle(obstacle), .bird_tail(bird_tail), .bird_head(bird_head),
    .push(push_d[1]), .busy(busy_d[1]), .gap_row(gap_d[1]));
  autopilot_flap_ctrl #(.MARGIN(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .game_tick(game_tick), .obs_valid(obs_valid),
    .obstacle(obstacle), .bird_tail(bird_tail), .bird_head(bird_head),
    .push(push_d[2]), .busy(busy_d[2]), .gap_row(gap_d[2]));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: push cycles still owed, cooldown ticks still owed, whether tracking has begun.
  int m_margin [3] = '{1, 1, 4};
  int m_cdt    [3] = '{2, 0, 2};
  int m_push   [3];
  int m_cd     [3];
  int m_gap    [3];
  bit m_act    [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int ref_gap(input logic [7:0] ob);
    for (int r = 1; r <= 5; r++) if (ob[r] == 1'b0) return r;
    return 5;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_push[k] = 0; m_cd[k] = 0; m_gap[k] = 5; m_act[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int gn, eff, lo, thr;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_push[k] = 0; m_cd[k] = 0; m_gap[k] = 5; m_act[k] = 1'b0;
      end else begin
        gn  = ref_gap(obstacle);
        eff = obs_valid ? gn : m_gap[k];
        lo  = (bird_tail < bird_head) ? int'(bird_tail) : int'(bird_head);
        thr = eff + m_margin[k];
        if (thr > 7) thr = 7;
        if (!enable) begin
          m_act[k] = 1'b0; m_push[k] = 0; m_cd[k] = 0;
        end else if (!m_act[k]) begin
          m_act[k] = 1'b1;
        end else if (m_push[k] > 0) begin
          m_push[k]--;
          if (m_push[k] == 0) m_cd[k] = m_cdt[k];
        end else if (m_cd[k] > 0) begin
          if (game_tick) m_cd[k]--;
        end else if (game_tick && lo <= thr) begin
          m_push[k] = 4;
        end
        if (obs_valid) m_gap[k] = gn;
      end
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("push[%0d]", k), 32'(push_d[k]), 32'(m_push[k] > 0));
      chk($sformatf("busy[%0d]", k), 32'(busy_d[k]), 32'(m_push[k] > 0 || m_cd[k] > 0));
      chk($sformatf("gap_row[%0d]", k), 32'(gap_d[k]), 32'(m_gap[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic cyc(input bit tk, input bit ov);
    game_tick = tk;
    obs_valid = ov;
    step();
    game_tick = 1'b0;
    obs_valid = 1'b0;
  endtask

  // Park every instance in TRACK with a low gap and the bird high, so no tick flaps.
  task automatic drain();
    obstacle = 8'hFD; bird_tail = 3'd7; bird_head = 3'd7;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(i % 2 == 0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] pre;
    logic [7:0] obs;
    bit         byp;
    logic [2:0] tail;
    logic [2:0] head;
    int         exp_gap;
    bit         exp_push;
    bit         exp_push_m4;
  } vec_t;

  vec_t vecs [8];
  int   cnt_dflt, cnt_cd0;

  initial begin
    vecs[0] = '{8'b1111_0011, 8'b1111_0011, 1'b0, 3'd2, 3'd3, 2, 1'b1, 1'b1};
    vecs[1] = '{8'b1111_0011, 8'b1111_0011, 1'b0, 3'd4, 3'd5, 2, 1'b0, 1'b1};
    vecs[2] = '{8'hFF,        8'hFF,        1'b0, 3'd6, 3'd7, 5, 1'b1, 1'b1};
    vecs[3] = '{8'hFF,        8'hFF,        1'b0, 3'd7, 3'd7, 5, 1'b0, 1'b1};
    vecs[4] = '{8'hFF,        8'b1111_1101, 1'b1, 3'd3, 3'd4, 1, 1'b0, 1'b1};
    vecs[5] = '{8'b1111_1101, 8'hFF,        1'b1, 3'd6, 3'd7, 5, 1'b1, 1'b1};
    vecs[6] = '{8'b0000_0001, 8'b0000_0001, 1'b0, 3'd2, 3'd0, 1, 1'b1, 1'b1};
    vecs[7] = '{8'b1111_1110, 8'b1111_1110, 1'b0, 3'd6, 3'd6, 5, 1'b1, 1'b1};

    model_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("rst_push", 32'(push_d[0]), 32'd0);
    chk("rst_busy", 32'(busy_d[0]), 32'd0);
    chk("rst_gap", 32'(gap_d[0]), 32'd5);

    rst_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("idle_push", 32'(push_d[0]), 32'd0);
    enable = 1'b1;
    cyc(1'b0, 1'b0);

    foreach (vecs[v]) begin
      drain();
      obstacle = vecs[v].pre; bird_tail = vecs[v].tail; bird_head = vecs[v].head;
      cyc(1'b0, 1'b1);
      obstacle = vecs[v].obs;
      cyc(1'b1, vecs[v].byp);
      chk($sformatf("vec%0d_gap", v), 32'(gap_d[0]), 32'(vecs[v].exp_gap));
      chk($sformatf("vec%0d_push", v), 32'(push_d[0]), 32'(vecs[v].exp_push));
      chk($sformatf("vec%0d_push_m4", v), 32'(push_d[2]), 32'(vecs[v].exp_push_m4));
    end

    // Tick every 3 cycles with the flap condition always true.
    drain();
    obstacle = 8'hFF; bird_tail = 3'd0; bird_head = 3'd0;
    cyc(1'b0, 1'b1);
    cnt_dflt = 0; cnt_cd0 = 0;
    for (int c = 0; c <= 40; c++) begin
      cyc(c % 3 == 0 && c <= 36, 1'b0);
      cnt_dflt += int'(push_d[0]);
      cnt_cd0  += int'(push_d[1]);
    end
    chk("cooldown_push_cycles", 32'(cnt_dflt), 32'd16);
    chk("nocooldown_push_cycles", 32'(cnt_cd0), 32'd28);

    // Disable during the second push cycle.
    drain();
    obstacle = 8'hFF; bird_tail = 3'd0; bird_head = 3'd0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("abort_push_start", 32'(push_d[0]), 32'd1);
    cyc(1'b0, 1'b0);
    enable = 1'b0;
    cyc(1'b0, 1'b0);
    chk("abort_push", 32'(push_d[0]), 32'd0);
    chk("abort_busy", 32'(busy_d[0]), 32'd0);
    enable = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("pre_reset_push", 32'(push_d[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk("async_reset_push", 32'(push_d[0]), 32'd0);
    cmp_all();
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      obstacle  = 8'($urandom);
      bird_tail = 3'($urandom_range(0, 7));
      bird_head = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
